// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types and constants for the PLL lock supervisor
//
// Holds the supervisor FSM state type, the width of the lock-loss statistics
// counter and the default values of the supervisor parameters.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_sup_state_t;

  localparam int LOCK_LOSS_CNT_W = 16;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_FILTER_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 1000000;
  localparam int DEF_MAX_RETRIES         = 7;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with asynchronous reset
//
// Ports:
//   clk  in        destination clock
//   rst  in        asynchronous active-high reset, clears both flops to 0
//   d    in WIDTH  asynchronous input
//   q    out WIDTH input resynchronized to clk (two-cycle latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock supervisor with filtered release and retries
//
// Drives the PLL reset, filters the PLL lock flag and releases the system
// reset once lock has been stable for LOCK_FILTER_CYCLES. Lock acquisition is
// retried up to MAX_RETRIES times before the supervisor parks in FAULT.
// Optional feature macro: PLL_LOCK_SUPERVISOR_STATS_EN builds the saturating
// lock-loss counter; without it lock_loss_count is tied to 0.
//
// Ports:
//   refclk          in   reference clock, the only clock
//   rst             in   asynchronous active-high reset
//   pll_locked      in   PLL lock flag, asynchronous to refclk
//   relock_req      in   single-cycle request to restart the PLL
//   pll_rst         out  PLL reset, active-high
//   sys_rst         out  downstream reset, active-high
//   ready           out  filtered lock held (~sys_rst)
//   fault           out  retries exhausted
//   retry_count     out  retries used in the current acquisition
//   lock_loss_count out  lock losses seen while running
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               pll_locked,
  input  logic                               relock_req,
  output logic                               pll_rst,
  output logic                               sys_rst,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [LOCK_LOSS_CNT_W-1:0]         lock_loss_count
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int PW = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int FW = (LOCK_FILTER_CYCLES > 1) ? $clog2(LOCK_FILTER_CYCLES) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);

  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  pll_sup_state_t state, state_nxt;
  logic            locked_s;
  logic [PW-1:0]   pulse_cnt, pulse_nxt;
  logic [FW-1:0]   filt_cnt, filt_nxt;
  logic [TW-1:0]   tmo_cnt, tmo_nxt;
  logic [RW-1:0]   retry_nxt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt = state;
    pulse_nxt = pulse_cnt;
    filt_nxt  = filt_cnt;
    tmo_nxt   = tmo_cnt;
    retry_nxt = retry_count;

    if (relock_req) begin
      // A requested restart overrides everything and starts a fresh acquisition.
      state_nxt = ST_RESET_PLL;
      pulse_nxt = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          tmo_nxt = '0;
          if (pulse_cnt == PULSE_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            pulse_nxt = '0;
          end else begin
            pulse_nxt = pulse_cnt + PW'(1);
          end
        end

        ST_WAIT_LOCK, ST_FILTER: begin
          // The timeout spans both states and survives filter bounces, and it
          // wins over a release that would land on the same edge.
          if (tmo_cnt == TMO_LAST) begin
            if (retry_count == RETRY_MAX) begin
              state_nxt = ST_FAULT;
            end else begin
              state_nxt = ST_RESET_PLL;
              pulse_nxt = '0;
              retry_nxt = retry_count + RW'(1);
            end
          end else begin
            tmo_nxt = tmo_cnt + TW'(1);
            if (state == ST_WAIT_LOCK) begin
              if (locked_s) begin
                state_nxt = ST_FILTER;
                filt_nxt  = '0;
              end
            end else if (!locked_s) begin
              state_nxt = ST_WAIT_LOCK;
            end else if (filt_cnt == FILT_LAST) begin
              state_nxt = ST_RUN;
              retry_nxt = '0;
            end else begin
              filt_nxt = filt_cnt + FW'(1);
            end
          end
        end

        ST_RUN: begin
          if (!locked_s) begin
            state_nxt = ST_RESET_PLL;
            pulse_nxt = '0;
          end
        end

        ST_FAULT: begin
          state_nxt = ST_FAULT;
        end

        default: begin
          state_nxt = ST_RESET_PLL;
          pulse_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the FSM.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state       <= ST_RESET_PLL;
      pulse_cnt   <= '0;
      filt_cnt    <= '0;
      tmo_cnt     <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pulse_cnt   <= pulse_nxt;
      filt_cnt    <= filt_nxt;
      tmo_cnt     <= tmo_nxt;
      retry_count <= retry_nxt;
      pll_rst     <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAULT);
      sys_rst     <= (state_nxt != ST_RUN);
      ready       <= (state_nxt == ST_RUN);
      fault       <= (state_nxt == ST_FAULT);
    end
  end

`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
  logic                       lock_lost;
  logic [LOCK_LOSS_CNT_W-1:0] loss_cnt;

  // A requested restart out of RUN is not a lock loss.
  assign lock_lost = (state == ST_RUN) && !locked_s && !relock_req;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
    end else if (lock_lost && (loss_cnt != {LOCK_LOSS_CNT_W{1'b1}})) begin
      loss_cnt <= loss_cnt + LOCK_LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_count = loss_cnt;
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard testbench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  localparam int R  = 4;
  localparam int F  = 8;
  localparam int TO = 32;
  localparam int MR = 2;
  localparam int RW = $clog2(MR + 1);

`ifdef PLL_LOCK_SUPERVISOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [4+RW+15:0] vec_t;
  typedef struct {
    int    at;
    vec_t  vec;
    string name;
  } exp_t;

  logic          refclk;
  logic          rst;
  logic          pll_locked;
  logic          relock_req;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic          fault;
  logic [RW-1:0] retry_count;
  logic [15:0]   lock_loss_count;

  int   checks;
  int   failures;
  int   cyc;
  int   m_loss;
  vec_t last_exp;
  vec_t prev;
  vec_t cur;
  exp_t me;
  exp_t exp_q[$];

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (R),
    .LOCK_FILTER_CYCLES  (F),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .relock_req      (relock_req),
    .pll_rst         (pll_rst),
    .sys_rst         (sys_rst),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  initial cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  function automatic vec_t mk(input bit p, input bit s, input bit r, input bit f,
                              input int rc, input int loss);
    return {p, s, r, f, RW'(rc), 16'(loss)};
  endfunction

  // Expected output changes, deduplicated so only real changes are queued.
  task automatic push_exp(input int at, input bit p, input bit s, input bit r,
                          input bit f, input int rc, input string name);
    exp_t e;
    vec_t v;
    v = mk(p, s, r, f, rc, STATS ? m_loss : 0);
    if (v != last_exp) begin
      e.at   = at;
      e.vec  = v;
      e.name = name;
      exp_q.push_back(e);
      last_exp = v;
    end
  endtask

  // Monitor: every output change pops the next expectation.
  always @(negedge refclk) begin
    cur = {pll_rst, sys_rst, ready, fault, retry_count, lock_loss_count};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change edge=%0d got=%h required=no_change", cyc, cur);
      end else begin
        me = exp_q.pop_front();
        if (me.at != cyc || me.vec !== cur) begin
          failures++;
          $display("FAIL %s edge=%0d got=%h required edge=%0d vec=%h",
                   me.name, cyc, cur, me.at, me.vec);
        end
      end
      prev = cur;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 400) begin
      @(negedge refclk);
      #1;
      k++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain_%s pending=%0d required=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Lock appears after the PLL reset ends at edge w; release lands 2+F edges
  // after the first sample of the final uninterrupted high run.
  task automatic acquire(input int w, input int dly, input bit glitch, input string tag);
    int t, g, rel;
    t   = w + ((dly > 0) ? dly : int'($urandom_range(1, 5)));
    g   = t + int'($urandom_range(1, F));
    rel = glitch ? g + 1 : t;
    push_exp(rel + 2 + F, 1'b0, 1'b0, 1'b1, 1'b0, 0, {tag, "_release"});
    to_cyc(t - 1);
    pll_locked = 1'b1;
    if (glitch) begin
      to_cyc(g - 1);
      pll_locked = 1'b0;
      to_cyc(g);
      pll_locked = 1'b1;
    end
    drain(tag);
  endtask

  task automatic relock(output int w, input string tag);
    int x;
    x = cyc + 1 + int'($urandom_range(0, 4));
    push_exp(x, 1'b1, 1'b1, 1'b0, 1'b0, 0, {tag, "_relock"});
    push_exp(x + R, 1'b0, 1'b1, 1'b0, 1'b0, 0, {tag, "_pulse_end"});
    to_cyc(x - 1);
    relock_req = 1'b1;
    pll_locked = 1'b0;
    to_cyc(x);
    relock_req = 1'b0;
    w = x + R;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, l, t, e;
    checks     = 0;
    failures   = 0;
    m_loss     = 0;
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    last_exp   = mk(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    prev       = last_exp;

    repeat (3) @(negedge refclk);
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_sys_rst", int'(sys_rst), 1);
    chk("reset_ready", int'(ready), 0);
    chk("reset_fault", int'(fault), 0);
    chk("reset_retry", int'(retry_count), 0);
    chk("reset_loss", int'(lock_loss_count), 0);

    rst = 1'b0;
    w = cyc + R;
    push_exp(w, 1'b0, 1'b1, 1'b0, 1'b0, 0, "first_pulse_end");

    for (int k = 0; k < 4; k++) begin
      acquire(w, (k == 0) ? 6 : 0, (k % 2) == 1, "lock_a");
      relock(w, "run");
      acquire(w, 0, (k % 2) == 0, "lock_b");

      l = cyc + 1 + int'($urandom_range(0, 4));
      if (m_loss < 65535) m_loss++;
      push_exp(l + 2, 1'b1, 1'b1, 1'b0, 1'b0, 0, "lock_loss");
      w = l + 2 + R;
      push_exp(w, 1'b0, 1'b1, 1'b0, 1'b0, 0, "loss_pulse_end");
      push_exp(w + TO, 1'b1, 1'b1, 1'b0, 1'b0, 1, "timeout1");
      w = w + TO + R;
      push_exp(w, 1'b0, 1'b1, 1'b0, 1'b0, 1, "retry1_pulse_end");
      to_cyc(l - 1);
      pll_locked = 1'b0;

      if ((k % 2) == 1) begin
        acquire(w, 0, k == 3, "retry_lock");
      end else begin
        push_exp(w + TO, 1'b1, 1'b1, 1'b0, 1'b0, 2, "timeout2");
        w = w + TO + R;
        push_exp(w, 1'b0, 1'b1, 1'b0, 1'b0, 2, "retry2_pulse_end");
        push_exp(w + TO, 1'b1, 1'b1, 1'b0, 1'b1, 2, "fault");
        drain("fault");
      end
      relock(w, "round_end");
    end

    // Asynchronous reset between edges while filtering.
    t = w + int'($urandom_range(1, 5));
    to_cyc(t - 1);
    pll_locked = 1'b1;
    e = t + 2 + int'($urandom_range(1, F - 2));
    to_cyc(e - 1);
    @(posedge refclk);
    #3;
    m_loss = 0;
    push_exp(cyc, 1'b1, 1'b1, 1'b0, 1'b0, 0, "async_rst");
    rst = 1'b1;
    #1;
    chk("async_pll_rst", int'(pll_rst), 1);
    chk("async_sys_rst", int'(sys_rst), 1);
    chk("async_ready", int'(ready), 0);
    chk("async_fault", int'(fault), 0);
    chk("async_retry", int'(retry_count), 0);
    chk("async_loss", int'(lock_loss_count), 0);

    repeat (2) @(negedge refclk);
    pll_locked = 1'b0;
    rst = 1'b0;
    w = cyc + R;
    push_exp(w, 1'b0, 1'b1, 1'b0, 1'b0, 0, "post_rst_pulse_end");
    acquire(w, 0, 1'b0, "post_rst");

    repeat (20) @(negedge refclk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
